// File: rtl/riscv_div_ctrl.sv
// RISC-V M-extension divide/remainder controller around one combinational unsigned divider.
// Optional last-result cache enabled by defining RISCV_DIV_RESULT_CACHE_EN.
module riscv_div_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_mag1;
  logic [31:0] r_mag2;
  logic        r_s1_neg;
  logic        r_s2_neg;
  logic [3:0]  r_cnt;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_signed;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  logic        w_hit;
  logic        w_capture;
  logic [31:0] w_special_res;
  logic [31:0] w_hit_res;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_calc_res;

  assign w_signed  = ~op[0];
  assign w_div0    = (rs2 == 32'd0);
  assign w_ovf     = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_special = w_div0 | w_ovf;
  assign w_accept  = in_valid & (r_state == IDLE) & ~kill;
  assign w_capture = (r_state == CALC) & (r_cnt == 4'd0) & ~kill;

  assign w_mag1 = (w_signed & rs1[31]) ? (32'd0 - rs1) : rs1;
  assign w_mag2 = (w_signed & rs2[31]) ? (32'd0 - rs2) : rs2;

  // Results for divide-by-zero and signed overflow, resolved at accept time.
  always_comb begin
    w_special_res = 32'd0;
    if (w_div0) begin
      w_special_res = op[1] ? rs1 : 32'hFFFF_FFFF;
    end else begin
      w_special_res = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Divisor is forced nonzero when idle so the divider never sees x/0.
  assign w_den      = (r_mag2 == 32'd0) ? 32'd1 : r_mag2;
  assign w_uq       = r_mag1 / w_den;
  assign w_ur       = r_mag1 % w_den;
  assign w_neg_q    = ~r_op[0] & (r_s1_neg ^ r_s2_neg);
  assign w_neg_r    = ~r_op[0] & r_s1_neg;
  assign w_q        = w_neg_q ? (32'd0 - w_uq) : w_uq;
  assign w_r        = w_neg_r ? (32'd0 - w_ur) : w_ur;
  assign w_calc_res = r_op[1] ? w_r : w_q;

`ifdef RISCV_DIV_RESULT_CACHE_EN
  logic        r_c_valid;
  logic        r_c_signed;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_c_rs1;
  logic [31:0] r_c_rs2;
  logic [31:0] r_c_q;
  logic [31:0] r_c_r;

  assign w_hit     = r_c_valid && !w_special && (rs1 == r_c_rs1) && (rs2 == r_c_rs2) &&
                     (w_signed == r_c_signed);
  assign w_hit_res = op[1] ? r_c_r : r_c_q;

  // Raw operand tags and the last completed normal quotient/remainder pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs1      <= 32'd0;
      r_rs2      <= 32'd0;
      r_c_valid  <= 1'b0;
      r_c_signed <= 1'b0;
      r_c_rs1    <= 32'd0;
      r_c_rs2    <= 32'd0;
      r_c_q      <= 32'd0;
      r_c_r      <= 32'd0;
    end else begin
      if (w_accept) begin
        r_rs1 <= rs1;
        r_rs2 <= rs2;
      end
      if ((r_state == CALC) && kill) begin
        r_c_valid <= 1'b0;
      end else if (w_capture) begin
        r_c_valid  <= 1'b1;
        r_c_signed <= ~r_op[0];
        r_c_rs1    <= r_rs1;
        r_c_rs2    <= r_rs2;
        r_c_q      <= w_q;
        r_c_r      <= w_r;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = 32'd0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; kill overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (kill) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_state_nxt = (w_special || w_hit) ? DONE : CALC;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        CALC: begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture, CALC down-counter and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= 2'd0;
      r_mag1   <= 32'd0;
      r_mag2   <= 32'd0;
      r_s1_neg <= 1'b0;
      r_s2_neg <= 1'b0;
      r_cnt    <= 4'd0;
      r_result <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op     <= op;
        r_mag1   <= w_mag1;
        r_mag2   <= w_mag2;
        r_s1_neg <= rs1[31];
        r_s2_neg <= rs2[31];
        r_cnt    <= CNT_INIT;
      end else if ((r_state == CALC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_accept && w_special) begin
        r_result <= w_special_res;
      end else if (w_accept && w_hit) begin
        r_result <= w_hit_res;
      end else if (w_capture) begin
        r_result <= w_calc_res;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

endmodule
